lsu_ctrl: RTL and testbench

- Load/store unit sitting directly upstream of data_memory: takes execute-stage requests (ALU-computed address, rs2 store data, funct3) and drives the data memory's address, data_in, width and write pins.
- Sign- or zero-extends load data and returns it to writeback through a valid/ready handshake.
- Detects misaligned and illegal-width accesses.

---
 rtl/lsu_ctrl_pkg.sv | 41 ++++
 rtl/lsu_load_extend.sv | 22 ++
 rtl/lsu_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: width codes, funct3 encodings, FSM states.
package lsu_ctrl_pkg;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // Access size minus one, so addr + result is the last byte touched.
  function automatic logic [2:0] width_bytes_m1(input logic [1:0] w);
    case (w)
      WIDTH_B: width_bytes_m1 = 3'd0;
      WIDTH_H: width_bytes_m1 = 3'd1;
      default: width_bytes_m1 = 3'd3;
    endcase
  endfunction

  function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [1:0] w);
    case (w)
      WIDTH_H: align_addr = {a[31:1], 1'b0};
      WIDTH_W: align_addr = {a[31:2], 2'b00};
      default: align_addr = a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Extracts the low byte/half/word of a memory read and sign- or zero-extends it.
module lsu_load_extend
  import lsu_ctrl_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  width_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = word_i;
    case (width_i)
      WIDTH_B: data_o = unsigned_i ? {24'b0, word_i[7:0]}
                                   : {{24{word_i[7]}}, word_i[7:0]};
      WIDTH_H: data_o = unsigned_i ? {16'b0, word_i[15:0]}
                                   : {{16{word_i[15]}}, word_i[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Non-pipelined load/store unit driving data_memory; returns extended load data over valid/ready.
// LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being aligned down.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_store,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic [ADDR_BITS-1:0] mem_address,
  output logic [31:0]          mem_data_in,
  output logic [1:0]           mem_width,
  output logic                 mem_write,
  input  logic [31:0]          mem_data_out
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  width_q, width_d;
  logic        uns_q, uns_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  req_width;
  logic [32:0] last_byte;
  logic        out_of_range;
  logic        misaligned;
  logic        illegal;
  logic [31:0] eff_addr;
  logic [31:0] ext_data;

  assign req_width = req_funct3[1:0];

  // Range uses the raw address so a straddling access faults even when aligned down.
  assign last_byte    = {1'b0, req_addr} + 33'(width_bytes_m1(req_width));
  assign out_of_range = last_byte >= 33'(MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_width == WIDTH_H) && req_addr[0]) ||
                      ((req_width == WIDTH_W) && (req_addr[1:0] != 2'b00));
  assign eff_addr   = req_addr;
`else
  assign misaligned = 1'b0;
  assign eff_addr   = align_addr(req_addr, req_width);
`endif

  assign illegal = (req_width == 2'b11) || (req_store && req_funct3[2]) ||
                   out_of_range || misaligned;

  lsu_load_extend u_extend (
    .word_i     (mem_data_out),
    .width_i    (width_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = eff_addr;
          wdata_d = req_wdata;
          width_d = req_width;
          uns_d   = req_funct3[2];
          rdata_d = 32'b0;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = req_store ? WRITE : READ;
          end
        end
      end
      READ: begin
        rdata_d = ext_data;
        state_d = RESP;
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      width_q <= 2'b00;
      uns_q   <= 1'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory pins are only live while an access is actually in progress.
  always_comb begin
    mem_address = '0;
    mem_data_in = 32'b0;
    mem_width   = 2'b00;
    mem_write   = 1'b0;
    if (state_q == READ || state_q == WRITE) begin
      mem_address = addr_q[ADDR_BITS-1:0];
      mem_width   = width_q;
    end
    if (state_q == WRITE) begin
      mem_data_in = wdata_q;
      mem_write   = 1'b1;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-array model of data_memory.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_width;
  logic        mem_write;
  logic [31:0] mem_data_out;

  int vectors;
  int miscompares;
  int writes;

  logic [7:0] mem [0:1023];
  logic [9:0] ma;

  lsu_ctrl #(.ADDR_BITS(32), .MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_width    (mem_width),
    .mem_write    (mem_write),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ma = mem_address[9:0];
  assign mem_data_out = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_write) begin
      writes = writes + 1;
      mem[ma] = mem_data_in[7:0];
      if (mem_width != 2'b00) mem[ma + 10'd1] = mem_data_in[15:8];
      if (mem_width == 2'b10) begin
        mem[ma + 10'd2] = mem_data_in[23:16];
        mem[ma + 10'd3] = mem_data_in[31:24];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input string sub, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %h expected %h", tag, sub, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    check(tag, "req_ready_before", {31'b0, req_ready}, 32'd1);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  // Latency counts edges from the accepting edge to the first edge resp_valid is seen high.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic complete(input string tag);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check(tag, "valid_drop", {31'b0, resp_valid}, 32'd0);
    check(tag, "ready_back", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic xact(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_lat, input int exp_writes);
    int lat;
    int wc;
    wc = writes;
    issue(tag, st, f3, a, wd);
    wait_resp(lat);
    check(tag, "latency", 32'(lat), 32'(exp_lat));
    check(tag, "rdata", resp_rdata, exp_rdata);
    check(tag, "err", {31'b0, resp_err}, {31'b0, exp_err});
    complete(tag);
    check(tag, "writes", 32'(writes - wc), 32'(exp_writes));
  endtask

  initial begin
    int lat;
    int wc;
    vectors     = 0;
    miscompares = 0;
    writes      = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset", "req_ready", {31'b0, req_ready}, 32'd1);
    check("reset", "resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset", "resp_err", {31'b0, resp_err}, 32'd0);
    check("reset", "resp_rdata", resp_rdata, 32'h0);
    check("reset", "mem_write", {31'b0, mem_write}, 32'd0);
    check("reset", "mem_address", mem_address, 32'h0);
    check("reset", "mem_data_in", mem_data_in, 32'h0);
    check("reset", "mem_width", {30'b0, mem_width}, 32'd0);

    // Store word: inspect the memory pins during the WRITE cycle.
    wc = writes;
    issue("sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check("sw", "mem_write", {31'b0, mem_write}, 32'd1);
    check("sw", "mem_address", mem_address, 32'h10);
    check("sw", "mem_width", {30'b0, mem_width}, 32'd2);
    check("sw", "mem_data_in", mem_data_in, 32'hDEADBEEF);
    wait_resp(lat);
    check("sw", "latency", 32'(lat), 32'd2);
    check("sw", "mem_write_off", {31'b0, mem_write}, 32'd0);
    check("sw", "rdata", resp_rdata, 32'h0);
    check("sw", "err", {31'b0, resp_err}, 32'd0);
    complete("sw");
    check("sw", "writes", 32'(writes - wc), 32'd1);

    xact("lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    xact("sb",  1'b1, 3'b000, 32'h20, 32'h12345680, 32'h0, 1'b0, 2, 1);
    xact("lb",  1'b0, 3'b000, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0);
    xact("lbu", 1'b0, 3'b100, 32'h20, 32'h0, 32'h00000080, 1'b0, 2, 0);
    xact("lw_after_sb", 1'b0, 3'b010, 32'h20, 32'h0, 32'h00000080, 1'b0, 2, 0);
    xact("sh",  1'b1, 3'b001, 32'h20, 32'hAAAA9234, 32'h0, 1'b0, 2, 1);
    xact("lh",  1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF9234, 1'b0, 2, 0);
    xact("lhu", 1'b0, 3'b101, 32'h20, 32'h0, 32'h00009234, 1'b0, 2, 0);
    xact("lw_after_sh", 1'b0, 3'b010, 32'h20, 32'h0, 32'h00009234, 1'b0, 2, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    xact("lw_misaligned", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("lh_misaligned", 1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1, 1, 0);
`else
    issue("lw_misaligned", 1'b0, 3'b010, 32'h12, 32'h0);
    check("lw_misaligned", "mem_address", mem_address, 32'h10);
    wait_resp(lat);
    check("lw_misaligned", "latency", 32'(lat), 32'd2);
    check("lw_misaligned", "rdata", resp_rdata, 32'hDEADBEEF);
    check("lw_misaligned", "err", {31'b0, resp_err}, 32'd0);
    complete("lw_misaligned");
    xact("lh_misaligned", 1'b0, 3'b001, 32'h21, 32'h0, 32'hFFFF9234, 1'b0, 2, 0);
`endif

    xact("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("sw_f3_110", 1'b1, 3'b110, 32'h10, 32'h11111111, 32'h0, 1'b1, 1, 0);
    xact("sw_oor",    1'b1, 3'b010, 32'h3FE, 32'h22222222, 32'h0, 1'b1, 1, 0);
    xact("lw_huge",   1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("lw_top",    1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0, 1'b0, 2, 0);
    xact("sb_top",    1'b1, 3'b000, 32'h3FF, 32'h0000005A, 32'h0, 1'b0, 2, 1);
    xact("lh_oor",    1'b0, 3'b001, 32'h3FF, 32'h0, 32'h0, 1'b1, 1, 0);
    xact("lw_still",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    // Backpressure: response held, a queued request must wait for IDLE.
    issue("bp", 1'b0, 3'b010, 32'h10, 32'h0);
    wait_resp(lat);
    check("bp", "latency", 32'(lat), 32'd2);
    req_store  = 1'b0;
    req_funct3 = 3'b100;
    req_addr   = 32'h3FF;
    req_wdata  = 32'h0;
    req_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp", "hold_valid", {31'b0, resp_valid}, 32'd1);
      check("bp", "hold_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp", "hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("bp", "valid_drop", {31'b0, resp_valid}, 32'd0);
    check("bp", "idle_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp", "accepted", {31'b0, req_ready}, 32'd0);
    wait_resp(lat);
    check("bp2", "latency", 32'(lat), 32'd2);
    check("bp2", "rdata", resp_rdata, 32'h0000005A);
    complete("bp2");

    // Always-ready writeback: resp_valid is a single-cycle pulse.
    resp_ready = 1'b1;
    issue("pulse", 1'b0, 3'b000, 32'h20, 32'h0);
    tick();
    check("pulse", "valid", {31'b0, resp_valid}, 32'd1);
    check("pulse", "rdata", resp_rdata, 32'h00000034);
    tick();
    check("pulse", "valid_drop", {31'b0, resp_valid}, 32'd0);
    resp_ready = 1'b0;

    // Reset while in WRITE.
    issue("rst_write", 1'b1, 3'b010, 32'h40, 32'h11223344);
    check("rst_write", "mem_write", {31'b0, mem_write}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_write", "mem_write_off", {31'b0, mem_write}, 32'd0);
    check("rst_write", "resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_write", "req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    check("rst_write", "no_resp", {31'b0, resp_valid}, 32'd0);

    // Reset coinciding with acceptance: the store must not happen.
    wc = writes;
    rst        = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h50;
    req_wdata  = 32'hCAFEF00D;
    req_valid  = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 1'b0;
    check("rst_accept", "mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_accept", "req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    tick();
    check("rst_accept", "writes", 32'(writes - wc), 32'd0);
    xact("rst_accept_lw", 1'b0, 3'b010, 32'h50, 32'h0, 32'h0, 1'b0, 2, 0);

    // Reset while in READ drops the response.
    issue("rst_read", 1'b0, 3'b010, 32'h10, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst_read", "no_resp", {31'b0, resp_valid}, 32'd0);
    check("rst_read", "req_ready", {31'b0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
